typed_pipeline: RTL and testbench



---
 rtl/typed_pipeline.sv | 122 ++++++++++++
 tb/tb_typed_pipeline.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/typed_pipeline.sv
// typed_pipeline: DEPTH-stage valid/ready pipeline carrying a common payload
// plus two type-qualified sideband fields (A, B). Each stage holds its token
// until the next stage accepts it; flush and reset drop all in-flight tokens.
module typed_pipeline #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned W_COMMON = 8,
  parameter int unsigned W_A      = 8,
  parameter int unsigned W_B      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic                       in_type_a,
  input  logic                       in_type_b,
  input  logic [W_COMMON-1:0]        in_data_common,
  input  logic [W_A-1:0]             in_data_a,
  input  logic [W_B-1:0]             in_data_b,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic                       out_type_a,
  output logic                       out_type_b,
  output logic [W_COMMON-1:0]        out_data_common,
  output logic [W_A-1:0]             out_data_a,
  output logic [W_B-1:0]             out_data_b,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]    vld;
  logic [DEPTH-1:0]    type_a;
  logic [DEPTH-1:0]    type_b;
  logic [W_COMMON-1:0] common [DEPTH];
  logic [W_A-1:0]      a      [DEPTH];
  logic [W_B-1:0]      b      [DEPTH];

  logic [DEPTH-1:0]    adv;
  logic [DEPTH-1:0]    load;
  logic [DEPTH-1:0]    up_ta;
  logic [DEPTH-1:0]    up_tb;
  logic [W_COMMON-1:0] up_common [DEPTH];
  logic [W_A-1:0]      up_a      [DEPTH];
  logic [W_B-1:0]      up_b      [DEPTH];
  logic [OW-1:0]       occ_cnt;

  // Ready chain, evaluated from the output stage back towards the input.
  always_comb begin
    adv          = '0;
    adv[DEPTH-1] = vld[DEPTH-1] & out_rdy;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = vld[DEPTH-1-k] & (~vld[DEPTH-k] | adv[DEPTH-k]);
    end
  end

  // Input acceptance: stage 0 free or draining, and no flush/reset this cycle.
  always_comb begin
    in_rdy = (~vld[0] | adv[0]) & ~flush & ~rst;
  end

  // Upstream view of every stage: stage 0 sees the input ports, others their predecessor.
  always_comb begin
    load         = '0;
    up_ta        = '0;
    up_tb        = '0;
    load[0]      = in_vld & in_rdy;
    up_ta[0]     = in_type_a;
    up_tb[0]     = in_type_b;
    up_common[0] = in_data_common;
    up_a[0]      = in_data_a;
    up_b[0]      = in_data_b;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      load[k]      = adv[k-1];
      up_ta[k]     = type_a[k-1];
      up_tb[k]     = type_b[k-1];
      up_common[k] = common[k-1];
      up_a[k]      = a[k-1];
      up_b[k]      = b[k-1];
    end
  end

  // Stage registers; A/B fields only overwrite when the incoming token is typed for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      type_a <= '0;
      type_b <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vld[i] <= load[i] | (vld[i] & ~adv[i]);
        if (load[i]) begin
          type_a[i] <= up_ta[i];
          type_b[i] <= up_tb[i];
          common[i] <= up_common[i];
          if (up_ta[i]) a[i] <= up_a[i];
          if (up_tb[i]) b[i] <= up_b[i];
        end
      end
    end
  end

  // Occupancy is the popcount of the stage valid bits.
  always_comb begin
    occ_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + OW'(vld[i]);
    end
  end

  assign occupancy       = occ_cnt;
  // Output valid is masked during flush/reset so no transfer completes in that cycle.
  assign out_vld         = vld[DEPTH-1] & ~flush & ~rst;
  assign out_type_a      = type_a[DEPTH-1];
  assign out_type_b      = type_b[DEPTH-1];
  assign out_data_common = common[DEPTH-1];
  assign out_data_a      = a[DEPTH-1];
  assign out_data_b      = b[DEPTH-1];

endmodule

// File: tb/tb_typed_pipeline.sv
// tb_typed_pipeline: scoreboard bench for typed_pipeline (DEPTH=3, 8-bit fields).
module tb_typed_pipeline;

  localparam int DEPTH = 3;

  typedef struct packed {
    logic [7:0] c;
    logic       ta;
    logic       tb;
    logic [7:0] a;
    logic [7:0] b;
  } tok_t;

  logic       clk = 1'b0;
  logic       rst, flush, in_vld, in_rdy, out_vld, out_rdy;
  logic       out_type_a, out_type_b;
  logic [7:0] out_data_common, out_data_a, out_data_b;
  logic [1:0] occupancy;
  tok_t       drv;

  tok_t        sb[$];
  tok_t        exp_t;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc_cnt  = 0;
  logic [7:0]  model_a, model_b;
  bit          a_known = 1'b0, b_known = 1'b0;

  typed_pipeline #(.DEPTH(DEPTH), .W_COMMON(8), .W_A(8), .W_B(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .in_type_a(drv.ta), .in_type_b(drv.tb),
    .in_data_common(drv.c), .in_data_a(drv.a), .in_data_b(drv.b),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_type_a(out_type_a), .out_type_b(out_type_b),
    .out_data_common(out_data_common), .out_data_a(out_data_a), .out_data_b(out_data_b),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurement.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic tok_t mk(input logic [7:0] c, input logic ta, input logic tb,
                              input logic [7:0] a, input logic [7:0] b);
    tok_t t;
    t.c = c; t.ta = ta; t.tb = tb; t.a = a; t.b = b;
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples handshakes on the falling edge.
  always @(negedge clk) begin
    if (rst || flush) begin
      check("gate_out_vld", 32'(out_vld), 32'd0);
      check("gate_in_rdy", 32'(in_rdy), 32'd0);
      sb.delete();
      a_known = 1'b0;
      b_known = 1'b0;
    end else begin
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t = sb.pop_front();
          check("out_common", 32'(out_data_common), 32'(exp_t.c));
          check("out_type_a", 32'(out_type_a), 32'(exp_t.ta));
          check("out_type_b", 32'(out_type_b), 32'(exp_t.tb));
          if (exp_t.ta) begin model_a = exp_t.a; a_known = 1'b1; end
          if (exp_t.tb) begin model_b = exp_t.b; b_known = 1'b1; end
          if (a_known) check("out_data_a", 32'(out_data_a), 32'(model_a));
          if (b_known) check("out_data_b", 32'(out_data_b), 32'(model_b));
        end
      end
      if (in_vld && in_rdy) sb.push_back(drv);
    end
  end

  task automatic send(input tok_t t, input bit rnd);
    int n = 0;
    drv    = t;
    in_vld = 1'b1;
    if (rnd) out_rdy = 1'($urandom_range(0, 1));
    #1;
    while (!in_rdy && n < 50) begin
      cyc();
      if (rnd) out_rdy = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (!in_rdy) check("send_timeout", 32'd0, 32'd1);
    cyc();
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_rdy = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    cyc();
  endtask

  initial begin
    tok_t        t3 [5];
    int          idx, n;
    int unsigned t0;

    rst = 1'b1; flush = 1'b0; out_rdy = 1'b0; in_vld = 1'b0; drv = '0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_type_a", 32'(out_type_a), 32'd0);
    check("rst_type_b", 32'(out_type_b), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);

    // Back-to-back streaming and latency.
    out_rdy = 1'b1;
    t0 = cyc_cnt;
    for (int k = 0; k < 3; k++) begin
      drv = mk(8'(8'h11 * (k + 1)), 1'b0, 1'b0, 8'h00, 8'h00);
      in_vld = 1'b1;
      #1;
      check("t1_in_rdy", 32'(in_rdy), 32'd1);
      cyc();
    end
    in_vld = 1'b0;
    n = 0;
    while (!out_vld && n < 10) begin cyc(); n++; end
    check("t1_latency", 32'(cyc_cnt - t0), 32'(DEPTH));
    check("t1_occ_peak", 32'(occupancy), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check("t1_out_vld", 32'(out_vld), 32'd1);
      check("t1_common", 32'(out_data_common), 32'(8'h11 * (k + 1)));
      cyc();
    end
    check("t1_empty_vld", 32'(out_vld), 32'd0);
    check("t1_empty_occ", 32'(occupancy), 32'd0);

    // Typed-field retention.
    send(mk(8'h21, 1'b1, 1'b0, 8'hA1, 8'h00), 1'b0);
    send(mk(8'h22, 1'b0, 1'b0, 8'hFF, 8'h5A), 1'b0);
    send(mk(8'h23, 1'b0, 1'b1, 8'h77, 8'hB3), 1'b0);
    drain();

    // Backpressure: five offered, three fit.
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) t3[k] = mk(8'(8'h31 + k), 1'b1, 1'b0, 8'(8'h41 + k), 8'h00);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drv = t3[idx]; in_vld = 1'b1;
      #1;
      if (in_rdy) idx++;
      cyc();
    end
    check("t3_accepted", 32'(idx), 32'd3);
    drv = t3[idx];
    #1;
    check("t3_in_rdy_stall", 32'(in_rdy), 32'd0);
    check("t3_occ_full", 32'(occupancy), 32'd3);
    for (int c = 0; c < 3; c++) begin
      check("t3_frozen_vld", 32'(out_vld), 32'd1);
      check("t3_frozen_common", 32'(out_data_common), 32'h31);
      check("t3_frozen_a", 32'(out_data_a), 32'h41);
      cyc();
    end
    out_rdy = 1'b1;
    #1;
    check("t3_in_rdy_release", 32'(in_rdy), 32'd1);
    n = 0;
    while (idx < 5 && n < 20) begin
      drv = t3[idx]; in_vld = 1'b1;
      #1;
      if (in_rdy) idx++;
      cyc();
      n++;
    end
    in_vld = 1'b0;
    check("t3_all_sent", 32'(idx), 32'd5);
    drain();

    // Sparse input, random output stalls.
    for (int k = 0; k < 20; k++) begin
      send(mk(8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom)), 1'b1);
      out_rdy = 1'($urandom_range(0, 1));
      cyc();
    end
    drain();

    // Flush with a full pipe and a pending token.
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) send(mk(8'(8'h51 + k), 1'b0, 1'b0, 8'h00, 8'h00), 1'b0);
    check("t5_occ_full", 32'(occupancy), 32'd3);
    drv = mk(8'h5F, 1'b1, 1'b1, 8'hC5, 8'hD5);
    in_vld = 1'b1; flush = 1'b1;
    #1;
    check("t5_flush_in_rdy", 32'(in_rdy), 32'd0);
    check("t5_flush_out_vld", 32'(out_vld), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    check("t5_occ_cleared", 32'(occupancy), 32'd0);
    check("t5_accept_after", 32'(in_rdy), 32'd1);
    cyc();
    in_vld = 1'b0;
    check("t5_occ_one", 32'(occupancy), 32'd1);
    drain();

    // Reset mid-stream.
    out_rdy = 1'b1;
    send(mk(8'h61, 1'b1, 1'b1, 8'hE1, 8'hF1), 1'b0);
    send(mk(8'h62, 1'b1, 1'b1, 8'hE2, 8'hF2), 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_out_vld", 32'(out_vld), 32'd0);
    check("t6_rst_in_rdy", 32'(in_rdy), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("t6_out_vld", 32'(out_vld), 32'd0);
    check("t6_type_a", 32'(out_type_a), 32'd0);
    check("t6_type_b", 32'(out_type_b), 32'd0);
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_in_rdy", 32'(in_rdy), 32'd1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      check("t6_no_ghost", 32'(out_vld), 32'd0);
    end
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
